// File: rtl/mr_arb_pkg.sv
// Shared widths, round-robin pick helper and clog2 for the montgomery_reduce arbiter.
// Used by mr_tag_fifo and montgomery_reduce_arbiter (optional macro: MR_ARB_PRIORITY_EN).
package mr_arb_pkg;

  localparam int MR_X_W = 26;
  localparam int MR_Y_W = 15;
  localparam int RR_MAX = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // First asserted request at or after ptr, wrapping within the n active requesters.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [2:0] ptr,
                                       input int n);
    rr_pick_t res;
    int k;
    res = '0;
    for (int off = 0; off < RR_MAX; off++) begin
      k = int'(ptr) + off;
      if (k >= n) k = k - n;
      if (off < n && !res.found && req[k[2:0]]) begin
        res.found = 1'b1;
        res.idx   = k[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mr_tag_fifo.sv
// In-order FIFO of requester tags for reductions in flight; count doubles as the outstanding counter.
// Pointers carry an extra MSB so full and empty are distinguishable without a separate flag.
import mr_arb_pkg::*;

module mr_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [CNT_W-1:0] count
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [TAG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

  assign head_tag = mem[rd_ptr[AW-1:0]];
  assign count    = CNT_W'(wr_ptr - rd_ptr);

endmodule

// File: rtl/montgomery_reduce_arbiter.sv
// Shares one pipelined montgomery_reduce unit among NUM_REQ requesters and routes results back in order.
// Optional macro MR_ARB_PRIORITY_EN: requester 0 always wins, the rest share round-robin.
import mr_arb_pkg::*;

module montgomery_reduce_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*MR_X_W-1:0] req_X,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [MR_Y_W-1:0]         resp_y,
  output logic                      mr_en,
  output logic [MR_X_W-1:0]         mr_X,
  input  logic [MR_Y_W-1:0]         mr_y,
  input  logic                      mr_valid,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      busy
);

  // Handshake: requester i transfers req_X[i] on a cycle where req_valid[i] and req_ready[i]
  // are both high; it holds both stable until then. req_ready is combinational and one-hot.

  logic [RR_MAX-1:0] req_pad;
  logic [TAG_W-1:0]  rr_ptr;
  rr_pick_t          pick;
  logic              full;
  logic              grant;
  logic [TAG_W-1:0]  win;
  logic [TAG_W-1:0]  head_tag;
  logic [CNT_W-1:0]  count;
  logic              pop;

  assign req_pad = RR_MAX'(req_valid);

  always_comb begin
    pick = '0;
`ifdef MR_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      pick.found = 1'b1;
      pick.idx   = '0;
    end else begin
      pick = rr_pick(req_pad & ~RR_MAX'(1), 3'(rr_ptr), NUM_REQ);
    end
`else
    pick = rr_pick(req_pad, 3'(rr_ptr), NUM_REQ);
`endif
  end

  // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot early.
  assign full      = (count == CNT_W'(DEPTH));
  assign grant     = pick.found & ~full & rst_n;
  assign win       = TAG_W'(pick.idx);
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
  assign pop       = mr_valid & (count != '0);

  mr_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grant),
    .push_tag (win),
    .pop      (pop),
    .head_tag (head_tag),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      mr_en      <= 1'b0;
      mr_X       <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
    end else begin
      mr_en <= grant;
      if (grant) begin
        mr_X <= req_X[int'(win)*MR_X_W +: MR_X_W];
`ifdef MR_ARB_PRIORITY_EN
        if (win != '0)
`endif
          rr_ptr <= (win == TAG_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end
      resp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (pop) resp_y <= mr_y;
    end
  end

  assign outstanding = count;
  assign busy        = (count != '0);

endmodule
